box_filter_core: RTL and testbench
==================================

// Module: box_filter_core
// PURPOSE
// - 3x3 mean (box) filter stage of the adaptive-thresholding pipeline.
// - Reads the 256x256 8-bit source image from the synchronous input ROM reader.
// - Writes one rounded 3x3 average per pixel into the middle RAM controller.
// - Asserts finished when the whole frame is written; the threshold stage consumes it.
// PARAMETERS
// - WIDTH_BITS   8    column address width; image width = 2**WIDTH_BITS
// - HEIGHT_BITS  8    row address width; image height = 2**HEIGHT_BITS
// PORTS
// - clock        in   1            single clock, all logic on rising edge
// - not_reset    in   1            synchronous, active-low reset
// - oImageCol    out  WIDTH_BITS   source ROM read column
// - oImageRow    out  HEIGHT_BITS  source ROM read row
// - iImageData   in   8            ROM data, valid 1 cycle after address
// - oResultCol   out  WIDTH_BITS   result RAM write column
// - oResultRow   out  HEIGHT_BITS  result RAM write row
// - oResultData  out  8            filtered pixel value
// - oResultWren  out  1            1-cycle write strobe
// - finished     out  1            frame complete, sticky
// BEHAVIOUR
// - Reset (not_reset=0 at clock edge): every output is 0 and the FSM is in ADDR tap 0
//   of pixel (0,0). Reset asserted mid-frame aborts the frame; the block restarts at
//   (0,0) and drops finished.
// - Pixels are processed in raster order, row outer (0..255) and col inner (0..255).
// - Per pixel the FSM runs 11 cycles:
//   - ADDR k (k=0..8): drive tap k address.
//     - Tap order: dy=-1,0,+1 outer; dx=-1,0,+1 inner.
//     - Tap address = clamp(row+dy, 0, 255), clamp(col+dx, 0, 255).
//     - Edge pixels are replicated.
//   - Accumulation: iImageData of tap k is added in the cycle after ADDR k
//     (during ADDR k+1, or during ACC for k=8).
//   - ACC: accumulate the last tap and compute the average.
//   - WRITE: oResultWren=1 for exactly one cycle.
//     - oResultCol/Row = current pixel; oResultData = average.
//     - Next cycle starts ADDR 0 of the next pixel.
// - Sum is 12 bits (max 9*255 = 2295); the accumulator clears at ADDR 0 of each pixel.
// - Average = (sum*7282 + 32768) >> 16.
//   - Equals round-to-nearest of sum/9 over the full range; max result 255.
//   - Computed in a 28-bit intermediate.
// - oResultCol/Row/Data hold their last values outside WRITE; only Wren qualifies them.
// - oImageCol/Row hold the last tap address during ACC/WRITE.
// - After the WRITE of (255,255): enter DONE.
//   - finished=1 from the next cycle and stays 1 until reset.
//   - No further reads or writes.
// - Frame length: 65536*11 = 720896 cycles from reset release to finished.
// - Exactly 65536 write strobes per frame, each address written once.
// TESTING
// - Constant image, all 100 -> every result = 100; 65536 writes; finished at cycle 720896.
// - Zero image, 255 at (col10,row10) -> results at cols/rows 9..11 = 28; all else 0.
// - Zero image, 90 at (0,0) -> corner checks:
//   - (0,0)=40 (replicated 4x); (1,0)=20; (0,1)=20; (1,1)=10; (2,2)=0.
// - Zero image, 200 at (255,255) -> (255,255)=89, (254,255)=44, (254,254)=22.
// - Reset pulsed mid-frame (~cycle 5000) -> outputs 0, finished 0.
//   - Writes restart at (0,0); full frame completes, finished rises once.
// - Timing -> Wren is 1 cycle wide, every 11th cycle; pixel(0,0) tap0 address (0,0) right after reset.

Source files
------------

// File: rtl/box_filter_core.sv
`default_nettype none
// ============================================================================
//  Module   : box_filter_core
//  Function : 3x3 rounded mean filter, ROM source image -> result RAM, raster order
//  Revision : 1.0  initial release
// ============================================================================
module box_filter_core #(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8
) (
   input  logic                   clock,
   input  logic                   not_reset,
   output logic [WIDTH_BITS-1:0]  oImageCol,
   output logic [HEIGHT_BITS-1:0] oImageRow,
   input  logic [7:0]             iImageData,
   output logic [WIDTH_BITS-1:0]  oResultCol,
   output logic [HEIGHT_BITS-1:0] oResultRow,
   output logic [7:0]             oResultData,
   output logic                   oResultWren,
   output logic                   finished
);

   localparam logic [WIDTH_BITS-1:0]  c_COL_MAX = '1;
   localparam logic [HEIGHT_BITS-1:0] c_ROW_MAX = '1;
   localparam logic [3:0]             c_LAST_TAP = 4'd8;

   typedef enum logic [1:0] {
      S_ADDR  = 2'd0,
      S_ACC   = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state, w_nextState;
   logic [3:0]             r_tap, w_nextTap;
   logic [WIDTH_BITS-1:0]  r_col, w_nextCol;
   logic [HEIGHT_BITS-1:0] r_row, w_nextRow;
   logic [11:0]            r_sum;
   logic [WIDTH_BITS-1:0]  r_resultCol;
   logic [HEIGHT_BITS-1:0] r_resultRow;
   logic [7:0]             r_resultData;

   logic [1:0]             w_dy, w_dx;
   logic [11:0]            w_sumFinal;
   logic [27:0]            w_product;
   logic [7:0]             w_average;
   logic                   w_unusedBits;

   always_ff @(posedge clock) begin
      if (!not_reset) begin
         r_state      <= S_ADDR;
         r_tap        <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_sum        <= '0;
         r_resultCol  <= '0;
         r_resultRow  <= '0;
         r_resultData <= '0;
      end else begin
         r_state <= w_nextState;
         r_tap   <= w_nextTap;
         r_col   <= w_nextCol;
         r_row   <= w_nextRow;
         // ROM data lags the address by one cycle, so tap k lands during tap k+1.
         if (r_state == S_ADDR) begin
            if (r_tap == 4'd0) r_sum <= '0;
            else               r_sum <= r_sum + {4'd0, iImageData};
         end
         if (r_state == S_ACC) begin
            r_resultCol  <= r_col;
            r_resultRow  <= r_row;
            r_resultData <= w_average;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextTap   = r_tap;
      w_nextCol   = r_col;
      w_nextRow   = r_row;
      case (r_state)
         S_ADDR: begin
            if (r_tap == c_LAST_TAP) w_nextState = S_ACC;
            else                     w_nextTap   = r_tap + 4'd1;
         end
         S_ACC: w_nextState = S_WRITE;
         S_WRITE: begin
            // Tap stays at 8 in DONE so the read address holds at the last tap.
            if (r_col == c_COL_MAX && r_row == c_ROW_MAX) begin
               w_nextState = S_DONE;
            end else begin
               w_nextState = S_ADDR;
               w_nextTap   = '0;
               if (r_col == c_COL_MAX) begin
                  w_nextCol = '0;
                  w_nextRow = r_row + 1'b1;
               end else begin
                  w_nextCol = r_col + 1'b1;
               end
            end
         end
         default: w_nextState = S_DONE;
      endcase
   end

   always_comb begin
      w_dy = 2'd2;
      w_dx = 2'd2;
      case (r_tap)
         4'd0: begin w_dy = 2'd0; w_dx = 2'd0; end
         4'd1: begin w_dy = 2'd0; w_dx = 2'd1; end
         4'd2: begin w_dy = 2'd0; w_dx = 2'd2; end
         4'd3: begin w_dy = 2'd1; w_dx = 2'd0; end
         4'd4: begin w_dy = 2'd1; w_dx = 2'd1; end
         4'd5: begin w_dy = 2'd1; w_dx = 2'd2; end
         4'd6: begin w_dy = 2'd2; w_dx = 2'd0; end
         4'd7: begin w_dy = 2'd2; w_dx = 2'd1; end
         default: begin w_dy = 2'd2; w_dx = 2'd2; end
      endcase
   end

   // Clamped neighbour address: border pixels replicate outward.
   always_comb begin
      oImageRow = r_row;
      oImageCol = r_col;
      if (w_dy == 2'd0 && r_row != '0)        oImageRow = r_row - 1'b1;
      if (w_dy == 2'd2 && r_row != c_ROW_MAX) oImageRow = r_row + 1'b1;
      if (w_dx == 2'd0 && r_col != '0)        oImageCol = r_col - 1'b1;
      if (w_dx == 2'd2 && r_col != c_COL_MAX) oImageCol = r_col + 1'b1;
   end

   // 7282/65536 approximates 1/9 closely enough to round correctly up to 2295.
   assign w_sumFinal   = r_sum + {4'd0, iImageData};
   assign w_product    = 28'(w_sumFinal) * 28'd7282 + 28'd32768;
   assign w_average    = w_product[23:16];
   assign w_unusedBits = &{1'b0, w_product[27:24], w_product[15:0]};

   assign oResultCol  = r_resultCol;
   assign oResultRow  = r_resultRow;
   assign oResultData = r_resultData;
   assign oResultWren = (r_state == S_WRITE);
   assign finished    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_box_filter_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_box_filter_core
//  Function : random and directed images on a reduced 16x8 frame vs a 3x3 mean model
//  Revision : 1.0  initial release
// ============================================================================
module tb_box_filter_core;

   localparam int WB   = 4;
   localparam int HB   = 3;
   localparam int COLS = 1 << WB;
   localparam int ROWS = 1 << HB;
   localparam int NPIX = COLS * ROWS;

   logic          clock;
   logic          not_reset;
   logic [WB-1:0] oImageCol;
   logic [HB-1:0] oImageRow;
   logic [7:0]    romData;
   logic [WB-1:0] oResultCol;
   logic [HB-1:0] oResultRow;
   logic [7:0]    oResultData;
   logic          oResultWren;
   logic          finished;

   logic [7:0] img [0:ROWS-1][0:COLS-1];
   int testCount;
   int failCount;

   box_filter_core #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
      .clock      (clock),
      .not_reset  (not_reset),
      .oImageCol  (oImageCol),
      .oImageRow  (oImageRow),
      .iImageData (romData),
      .oResultCol (oResultCol),
      .oResultRow (oResultRow),
      .oResultData(oResultData),
      .oResultWren(oResultWren),
      .finished   (finished)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous ROM: data valid one cycle after the address.
   always @(posedge clock) romData <= img[oImageRow][oImageCol];

   task automatic checkValue(input string tag, input int observed, input int expected);
      testCount++;
      if (observed != expected) begin
         failCount++;
         $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic int refPixel(input int r, input int c);
      int sum = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            sum += img[clampi(r + dy, ROWS - 1)][clampi(c + dx, COLS - 1)];
      return (sum + 4) / 9;
   endfunction

   task automatic fillConst(input int v);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            img[r][c] = 8'(v);
   endtask

   task automatic fillRandom();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            img[r][c] = 8'($urandom_range(0, 255));
   endtask

   task automatic checkReset(input string tag);
      checkValue({tag, "_imgCol"}, int'(oImageCol), 0);
      checkValue({tag, "_imgRow"}, int'(oImageRow), 0);
      checkValue({tag, "_resCol"}, int'(oResultCol), 0);
      checkValue({tag, "_resRow"}, int'(oResultRow), 0);
      checkValue({tag, "_resData"}, int'(oResultData), 0);
      checkValue({tag, "_wren"}, int'(oResultWren), 0);
      checkValue({tag, "_finished"}, int'(finished), 0);
   endtask

   // Runs one frame from reset; abortAt >= 0 pulls reset low at that cycle.
   task automatic runFrame(input int abortAt);
      int  writes = 0;
      bit  done = 0;
      int  p, ph, r, c, tdy, tdx;
      not_reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkReset("reset");
      not_reset = 1'b1;
      for (int cyc = 0; cyc < NPIX * 11 + 20 && !done; cyc++) begin
         @(negedge clock);
         if (cyc < NPIX * 11) begin
            p  = cyc / 11;
            ph = cyc % 11;
            r  = p / COLS;
            c  = p % COLS;
            tdy = (ph < 9) ? ph / 3 - 1 : 1;
            tdx = (ph < 9) ? ph % 3 - 1 : 1;
            checkValue("tap_col", int'(oImageCol), clampi(c + tdx, COLS - 1));
            checkValue("tap_row", int'(oImageRow), clampi(r + tdy, ROWS - 1));
            checkValue("wren", int'(oResultWren), (ph == 10) ? 1 : 0);
            checkValue("finished_early", int'(finished), 0);
            if (oResultWren) begin
               checkValue("wr_index", writes, p);
               checkValue("wr_col", int'(oResultCol), c);
               checkValue("wr_row", int'(oResultRow), r);
               checkValue("wr_data", int'(oResultData), refPixel(r, c));
               writes++;
            end
         end else begin
            checkValue("finished", int'(finished), 1);
            checkValue("wren_after_done", int'(oResultWren), 0);
         end
         if (cyc == abortAt) begin
            not_reset = 1'b0;
            @(posedge clock);
            #1;
            checkReset("midreset");
            done = 1;
         end
      end
      if (abortAt < 0) checkValue("write_count", writes, NPIX);
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      not_reset = 1'b0;
      fillConst(0);

      fillConst(100);
      runFrame(-1);

      fillConst(0);
      img[5][10] = 8'd255;
      runFrame(-1);

      fillConst(0);
      img[0][0] = 8'd90;
      runFrame(-1);

      fillConst(0);
      img[ROWS-1][COLS-1] = 8'd200;
      runFrame(-1);

      fillConst(255);
      runFrame(-1);

      fillRandom();
      runFrame(500);
      fillRandom();
      runFrame(-1);

      repeat (2) begin
         fillRandom();
         runFrame(-1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
`default_nettype wire
